// File: rtl/fp_div_issuer_if.sv
// rtl/fp_div_issuer_if.sv - job request, divider operand/result and response channels of fp_div_issuer
interface fp_div_issuer_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [TAG_W-1:0] req_tag;

    logic [WIDTH-1:0] input_a;
    logic             input_a_stb;
    logic             input_a_ack;
    logic [WIDTH-1:0] input_b;
    logic             input_b_stb;
    logic             input_b_ack;
    logic [WIDTH-1:0] output_z;
    logic             output_z_stb;
    logic             output_z_ack;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_z;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    // The issuer side
    modport master (
        input  req_valid, req_a, req_b, req_tag,
        output req_ready,
        output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
        input  input_a_ack, input_b_ack, output_z, output_z_stb,
        output rsp_valid, rsp_z, rsp_tag, rsp_err,
        input  rsp_ready
    );

    // The scheduler/divider side
    modport slave (
        output req_valid, req_a, req_b, req_tag,
        input  req_ready,
        input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
        output input_a_ack, input_b_ack, output_z, output_z_stb,
        input  rsp_valid, rsp_z, rsp_tag, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/fp_div_issuer.sv
// rtl/fp_div_issuer.sv - one-job-in-flight initiator for the divider stb/ack protocol (watchdog: FP_DIV_ISSUER_TIMEOUT_EN)
module fp_div_issuer #(
    parameter int WIDTH       = 32,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            clk,
    input  logic            rst,
    fp_div_issuer_if.master bus,
    output logic            busy,
    output logic [15:0]     issue_count
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_Z = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;

    logic a_xfer;
    logic b_xfer;
    logic a_pending;
    logic b_pending;
    logic z_xfer;
    logic rsp_xfer;

    assign a_xfer    = bus.input_a_stb & bus.input_a_ack;
    assign b_xfer    = bus.input_b_stb & bus.input_b_ack;
    // An operand is still outstanding if its strobe stays up past this edge
    assign a_pending = bus.input_a_stb & ~bus.input_a_ack;
    assign b_pending = bus.input_b_stb & ~bus.input_b_ack;
    assign z_xfer    = bus.output_z_stb & bus.output_z_ack;
    assign rsp_xfer  = bus.rsp_valid & bus.rsp_ready;

`ifdef FP_DIV_ISSUER_TIMEOUT_EN
    localparam logic [WIDTH-1:0] QNAN  = WIDTH'(32'h7FC0_0000);
    localparam logic [15:0]      LIMIT = 16'(TIMEOUT_CYC - 1);

    logic [15:0] wd_cnt;
    logic        wd_abort;

    // A result arriving on the very last cycle still wins over the abort
    assign wd_abort = (wd_cnt == LIMIT) &&
                      ((state == SEND) || ((state == WAIT_Z) && !z_xfer));
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Job sequencer; every handshake output is a register written only here
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            bus.req_ready    <= 1'b1;
            bus.input_a      <= '0;
            bus.input_b      <= '0;
            bus.input_a_stb  <= 1'b0;
            bus.input_b_stb  <= 1'b0;
            bus.output_z_ack <= 1'b0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_z        <= '0;
            bus.rsp_tag      <= '0;
            busy             <= 1'b0;
            issue_count      <= '0;
`ifdef FP_DIV_ISSUER_TIMEOUT_EN
            bus.rsp_err      <= 1'b0;
            wd_cnt           <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.input_a     <= bus.req_a;
                        bus.input_b     <= bus.req_b;
                        bus.rsp_tag     <= bus.req_tag;
                        bus.input_a_stb <= 1'b1;
                        bus.input_b_stb <= 1'b1;
                        bus.req_ready   <= 1'b0;
                        busy            <= 1'b1;
                        state           <= SEND;
                    end
                end
                SEND: begin
                    // Each operand channel retires independently, in any order
                    if (a_xfer) begin
                        bus.input_a_stb <= 1'b0;
                    end
                    if (b_xfer) begin
                        bus.input_b_stb <= 1'b0;
                    end
                    if (!a_pending && !b_pending) begin
                        bus.output_z_ack <= 1'b1;
                        state            <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (z_xfer) begin
                        bus.rsp_z        <= bus.output_z;
                        bus.output_z_ack <= 1'b0;
                        bus.rsp_valid    <= 1'b1;
                        state            <= RESP;
                    end
                end
                RESP: begin
                    // Ready returns only after the transfer, leaving a one-cycle bubble
                    if (rsp_xfer) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        busy          <= 1'b0;
                        issue_count   <= issue_count + 16'd1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef FP_DIV_ISSUER_TIMEOUT_EN
            if (state == IDLE) begin
                wd_cnt <= '0;
            end else if ((state == SEND) || (state == WAIT_Z)) begin
                wd_cnt <= wd_cnt + 16'd1;
            end

            // Abort overrides whatever the case above scheduled for this edge
            if (wd_abort) begin
                bus.input_a_stb  <= 1'b0;
                bus.input_b_stb  <= 1'b0;
                bus.output_z_ack <= 1'b0;
                bus.rsp_z        <= QNAN;
                bus.rsp_err      <= 1'b1;
                bus.rsp_valid    <= 1'b1;
                state            <= RESP;
            end

            if ((state == RESP) && rsp_xfer) begin
                bus.rsp_err <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_fp_div_issuer.sv
// tb/tb_fp_div_issuer.sv - scoreboard bench for fp_div_issuer with a behavioural divider
module tb_fp_div_issuer;
`ifdef FP_DIV_ISSUER_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif
    localparam logic [127:0] RST_VEC = {5'b0, 7'b1000000, 96'b0, 4'b0, 16'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] issue_count;

    fp_div_issuer_if #(.WIDTH(32), .TAG_W(4)) bus ();

    fp_div_issuer #(.WIDTH(32), .TAG_W(4), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [36:0] exp_q[$];
    logic [31:0] z_q[$];
    int          acc_q[$];
    int          rv_rise_q[$];
    int          rsp_xfer_q[$];
    int          n_rsp = 0;
    int          cyc   = 0;

    int a_lat = 0, b_lat = 0, z_lat = 0;
    bit z_never = 1'b0;

    int          last_a_hi, last_b_hi, last_done_cyc, last_zack_first, last_zack_early;
    logic [31:0] last_op_a, last_op_b;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] out_vec();
        return {5'b0, bus.req_ready, busy, bus.input_a_stb, bus.input_b_stb, bus.output_z_ack,
                bus.rsp_valid, bus.rsp_err, bus.input_a, bus.input_b, bus.rsp_z, bus.rsp_tag, issue_count};
    endfunction

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1000;
    endfunction

    // Behavioural divider: acks each operand after a programmable delay, then returns a queued quotient
    initial begin : divider_model
        int mcyc = 0;
        bit a_ack = 0, b_ack = 0, a_done = 0, b_done = 0, z_stb = 0, zack_prev = 0;
        int a_wait = 0, b_wait = 0, z_wait = 0, a_hi = 0, b_hi = 0;
        int done_cyc = -1, zack_first = -1, zack_early = 0;
        logic [31:0] op_a = '0, op_b = '0, z_val = '0;
        bus.input_a_ack  = 1'b0;
        bus.input_b_ack  = 1'b0;
        bus.output_z_stb = 1'b0;
        bus.output_z     = '0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (rst) begin
                a_ack = 0; b_ack = 0; a_done = 0; b_done = 0; z_stb = 0;
                a_wait = 0; b_wait = 0; z_wait = 0; a_hi = 0; b_hi = 0;
                done_cyc = -1; zack_first = -1; zack_early = 0;
                z_q.delete();
            end else begin
                if (a_ack) begin
                    a_ack = 0; a_done = 1;
                end else if (bus.input_a_stb && !a_done) begin
                    if (a_wait == a_lat) begin a_ack = 1; op_a = bus.input_a; end
                    else a_wait++;
                end
                if (bus.input_a_stb) a_hi++;
                if (b_ack) begin
                    b_ack = 0; b_done = 1;
                end else if (bus.input_b_stb && !b_done) begin
                    if (b_wait == b_lat) begin b_ack = 1; op_b = bus.input_b; end
                    else b_wait++;
                end
                if (bus.input_b_stb) b_hi++;
                if (a_done && b_done && done_cyc < 0) done_cyc = mcyc;
                if (bus.output_z_ack) begin
                    if (!(a_done && b_done)) zack_early++;
                    if (zack_first < 0) zack_first = mcyc;
                end
                if (z_stb && zack_prev) begin
                    z_stb = 0;
                    last_a_hi = a_hi; last_b_hi = b_hi; last_done_cyc = done_cyc;
                    last_zack_first = zack_first; last_zack_early = zack_early;
                    last_op_a = op_a; last_op_b = op_b;
                    a_done = 0; b_done = 0; a_wait = 0; b_wait = 0; z_wait = 0;
                    a_hi = 0; b_hi = 0; done_cyc = -1; zack_first = -1; zack_early = 0;
                end else if (a_done && b_done && !z_stb && !z_never && z_q.size() > 0) begin
                    if (z_wait == z_lat) begin z_stb = 1; z_val = z_q.pop_front(); end
                    else z_wait++;
                end
            end
            zack_prev        = bus.output_z_ack;
            bus.input_a_ack  = a_ack;
            bus.input_b_ack  = b_ack;
            bus.output_z_stb = z_stb;
            bus.output_z     = z_val;
        end
    end

    // Monitor: logs handshake timing and pops the scoreboard on each response transfer
    initial begin : monitor
        bit rv_prev = 0;
        logic [36:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
                if (bus.rsp_valid && !rv_prev) rv_rise_q.push_back(cyc);
                if (bus.rsp_valid && bus.rsp_ready) begin
                    rsp_xfer_q.push_back(cyc);
                    n_rsp++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rsp_unexpected: actual z=%h tag=%0d required no response",
                                 bus.rsp_z, bus.rsp_tag);
                    end else begin
                        e = exp_q.pop_front();
                        n_checks--;
                        check("rsp", 128'({bus.rsp_z, bus.rsp_tag, bus.rsp_err}), 128'(e));
                    end
                end
            end
            rv_prev = bus.rsp_valid;
        end
    end

    initial begin : global_timeout
        #300000;
        $display("FAIL global_timeout: actual stuck required completion");
        $fatal(1, "bench timeout");
    end

    task automatic clear_logs();
        acc_q.delete(); rv_rise_q.delete(); rsp_xfer_q.delete();
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] z, input bit err, input bit push_z, input bit keep);
        int k;
        bus.req_a = a; bus.req_b = b; bus.req_tag = tag; bus.req_valid = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.req_ready) break;
        end
        if (k == 200) begin
            check("req_accept_timeout", 128'(bus.req_ready), 128'(1));
        end else begin
            exp_q.push_back({z, tag, err});
            if (push_z) z_q.push_back(z);
        end
        @(posedge clk); #1;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain", 128'(exp_q.size()), 128'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp_valid();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        check("rsp_valid_seen", 128'(bus.rsp_valid), 128'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_q.delete();
        rst = 1'b0;
    endtask

    initial begin : stimulus
        int bad;
        int nb;
        int k;
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", out_vec(), RST_VEC);
        @(posedge clk); #1;

        // 1: single job, zero divider delay
        clear_logs();
        a_lat = 0; b_lat = 0; z_lat = 0;
        issue(32'h41C8_0000, 32'h4000_0000, 4'd3, 32'h4148_0000, 1'b0, 1'b1, 1'b0);
        drain();
        check("t1_stb_cycles", 128'({last_a_hi, last_b_hi}), 128'({32'd1, 32'd1}));
        check("t1_operands", 128'({last_op_a, last_op_b}), 128'({32'h41C8_0000, 32'h4000_0000}));
        check("t1_latency", 128'(qget(rv_rise_q, 0) - qget(acc_q, 0)), 128'(3));
        check("t1_issue_count", 128'(issue_count), 128'(1));

        // 2: operand acks skewed, A in SEND cycle 2, B in cycle 5
        a_lat = 1; b_lat = 4; z_lat = 1;
        issue(32'h40C0_0000, 32'h4040_0000, 4'd7, 32'h4000_0000, 1'b0, 1'b1, 1'b0);
        drain();
        check("t2_stb_cycles", 128'({last_a_hi, last_b_hi}), 128'({32'd2, 32'd5}));
        check("t2_zack_rise", 128'(last_zack_first), 128'(last_done_cyc));
        check("t2_zack_early", 128'(last_zack_early), 128'(0));

        // 3: downstream stalls for 10 cycles
        a_lat = 0; b_lat = 0; z_lat = 2;
        bus.rsp_ready = 1'b0;
        issue(32'h4110_0000, 32'h4040_0000, 4'd9, 32'h4040_0000, 1'b0, 1'b1, 1'b0);
        wait_rsp_valid();
        bad = 0;
        for (k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_z !== 32'h4040_0000 ||
                bus.rsp_tag !== 4'd9 || bus.req_ready !== 1'b0) bad++;
        end
        check("t3_hold_stable", 128'(bad), 128'(0));
        nb = n_rsp;
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t3_one_xfer", 128'(n_rsp - nb), 128'(1));
        check("t3_issue_count", 128'(issue_count), 128'(3));

        // 4: reset while waiting on the quotient
        z_lat = 20;
        issue(32'h41C8_0000, 32'h4000_0000, 4'd1, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.output_z_ack) break;
        end
        check("t4_in_wait_z", 128'(bus.output_z_ack), 128'(1));
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t4_mid_reset", out_vec(), RST_VEC);
        @(posedge clk); #1;
        z_lat = 2;
        issue(32'h4080_0000, 32'h4000_0000, 4'd2, 32'h4000_0000, 1'b0, 1'b1, 1'b0);
        drain();
        check("t4_issue_count", 128'(issue_count), 128'(1));

        // 5: four back-to-back jobs with req_valid held
        do_reset();
        clear_logs();
        a_lat = 0; b_lat = 1; z_lat = 3;
        issue(32'h40C0_0000, 32'h4040_0000, 4'd0, 32'h4000_0000, 1'b0, 1'b1, 1'b1);
        issue(32'h3F80_0000, 32'h4000_0000, 4'd1, 32'h3F00_0000, 1'b0, 1'b1, 1'b1);
        issue(32'h4110_0000, 32'h4040_0000, 4'd2, 32'h4040_0000, 1'b0, 1'b1, 1'b1);
        issue(32'hC100_0000, 32'h4000_0000, 4'd3, 32'hC080_0000, 1'b0, 1'b1, 1'b0);
        drain();
        for (int i = 1; i < 4; i++) begin
            check($sformatf("t5_bubble_%0d", i),
                  128'(qget(acc_q, i) - qget(rsp_xfer_q, i - 1)), 128'(1));
        end
        check("t5_issue_count", 128'(issue_count), 128'(4));

`ifdef FP_DIV_ISSUER_TIMEOUT_EN
        // 6: divider never answers, watchdog returns qNaN with error
        do_reset();
        clear_logs();
        a_lat = 0; b_lat = 0; z_never = 1'b1;
        issue(32'h3F80_0000, 32'h4000_0000, 4'd5, 32'h7FC0_0000, 1'b1, 1'b0, 1'b0);
        wait_rsp_valid();
        #1;
        check("t6_timeout_latency", 128'(qget(rv_rise_q, 0) - qget(acc_q, 0)), 128'(17));
        check("t6_outputs", 128'({bus.output_z_ack, bus.input_a_stb, bus.input_b_stb, bus.rsp_err}),
              128'(4'b0001));
        drain();
        check("t6_err_cleared", 128'(bus.rsp_err), 128'(0));
        check("t6_issue_count", 128'(issue_count), 128'(1));
        z_never = 1'b0;
        do_reset();
`endif

        check("sb_empty", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
